// File: rtl/delay_sram_arbiter_pkg.sv
// delay_sram_arbiter shared types.
// Allocation FSM encoding and requester count.
package delay_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    DSRAM_STATE_IDLE   = 2'd0,
    DSRAM_STATE_SCAN   = 2'd1,
    DSRAM_STATE_COMMIT = 2'd2,
    DSRAM_STATE_DONE   = 2'd3
  } dsram_state_e;

  localparam int NREQ = 2;

endpackage

// File: rtl/delay_sram_arbiter_bank_table.sv
// Per-bank {valid, owner} table for the delay SRAM.
// Parallel free, single-bank commit, two lookups, one scan port.
module delay_sram_arbiter_bank_table
  import delay_sram_arbiter_pkg::*;
#(
  parameter int n_banks = 64,
  localparam int BW = $clog2(n_banks)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              free_en,
  input  logic              free_owner,
  input  logic              commit_en,
  input  logic [BW-1:0]     commit_bank,
  input  logic              commit_owner,
  input  logic [2*BW-1:0]   lk_bank,
  output logic [NREQ-1:0]   lk_hit,
  input  logic [BW-1:0]     scan_bank,
  output logic              scan_free
);

  logic [n_banks-1:0] valid_q;
  logic [n_banks-1:0] owner_q;
  logic [BW-1:0]      lk0;
  logic [BW-1:0]      lk1;

  assign lk0 = lk_bank[BW-1:0];
  assign lk1 = lk_bank[2*BW-1:BW];

  // A requester hits only a valid bank carrying its own index.
  assign lk_hit[0] = valid_q[lk0] & ~owner_q[lk0];
  assign lk_hit[1] = valid_q[lk1] & owner_q[lk1];

  assign scan_free = ~valid_q[scan_bank];

  // Release all banks of one owner at once, or claim one bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      if (free_en) begin
        for (int b = 0; b < n_banks; b++) begin
          if (owner_q[b] == free_owner) begin
            valid_q[b] <= 1'b0;
          end
        end
      end
      if (commit_en) begin
        valid_q[commit_bank] <= 1'b1;
        owner_q[commit_bank] <= commit_owner;
      end
    end
  end

endmodule

// File: rtl/delay_sram_arbiter.sv
// Delay-line SRAM owner: bank-run allocator plus
// round-robin word-access arbiter for two DSP pipelines.
module delay_sram_arbiter
  import delay_sram_arbiter_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int n_sram_banks   = 64,
  parameter int sram_bank_size = 1024,
  localparam int BW = $clog2(n_sram_banks),
  localparam int OW = $clog2(sram_bank_size),
  localparam int AW = BW + OW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_req,
  input  logic                    alloc_owner,
  input  logic [BW:0]             alloc_n_banks,
  output logic                    alloc_done,
  output logic                    alloc_fail,
  output logic [BW-1:0]           alloc_base,
  input  logic                    free_req,
  input  logic                    free_owner,
  output logic                    free_done,
  output logic                    busy,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*AW-1:0]         addr,
  input  logic [2*data_width-1:0] wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              err,
  output logic [1:0]              rvalid,
  output logic [data_width-1:0]   rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [data_width-1:0]   mem_wdata,
  input  logic [data_width-1:0]   mem_rdata
);

  localparam logic [BW-1:0] LAST  = BW'(n_sram_banks - 1);
  localparam logic [BW-1:0] ONE_B = BW'(1);
  localparam logic [BW:0]   ONE_N = (BW+1)'(1);

  dsram_state_e    state;
  logic            own_q;
  logic [BW:0]     n_q;
  logic [BW:0]     run;
  logic [BW-1:0]   cursor;
  logic [BW-1:0]   base;
  logic [BW-1:0]   cidx;
  logic [BW-1:0]   scan_base;
  logic            fail_q;

  logic            free_en;
  logic            commit_en;
  logic            scan_free;
  logic [1:0]      lk_hit;

  logic            rr;
  logic [1:0]      rd_pend;
  logic [1:0]      cand;
  logic            any;
  logic            sel;
  logic [AW-1:0]   sel_addr;
  logic [data_width-1:0] sel_wdata;

  assign busy      = (state != DSRAM_STATE_IDLE);
  assign free_en   = free_req & (state == DSRAM_STATE_IDLE);
  assign commit_en = (state == DSRAM_STATE_COMMIT);
  assign scan_base = cursor - n_q[BW-1:0] + ONE_B;

  // The macro already registers its read port, so rdata is
  // passed straight through and qualified by rvalid.
  assign rdata = mem_rdata;

  delay_sram_arbiter_bank_table #(
    .n_banks (n_sram_banks)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .free_en      (free_en),
    .free_owner   (free_owner),
    .commit_en    (commit_en),
    .commit_bank  (cidx),
    .commit_owner (own_q),
    .lk_bank      ({addr[2*AW-1 -: BW], addr[AW-1 -: BW]}),
    .lk_hit       (lk_hit),
    .scan_bank    (cursor),
    .scan_free    (scan_free)
  );

  // Pick a requester; one answered last cycle sits out once so
  // its held request is not issued twice.
  always_comb begin
    cand      = req & ~(gnt | err);
    any       = |cand;
    sel       = (&cand) ? rr : cand[1];
    sel_addr  = sel ? addr[2*AW-1:AW] : addr[AW-1:0];
    sel_wdata = sel ? wdata[2*data_width-1:data_width]
                    : wdata[data_width-1:0];
  end

  // Issue the chosen access or reject it; track pending reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr        <= 1'b0;
      gnt       <= '0;
      err       <= '0;
      rd_pend   <= '0;
      rvalid    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt     <= '0;
      err     <= '0;
      rd_pend <= '0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      rvalid  <= rd_pend;
      if (any) begin
        rr <= ~rr;
        if (lk_hit[sel]) begin
          gnt[sel]     <= 1'b1;
          mem_en       <= 1'b1;
          mem_we       <= we[sel];
          mem_addr     <= sel_addr;
          mem_wdata    <= sel_wdata;
          rd_pend[sel] <= ~we[sel];
        end else begin
          err[sel] <= 1'b1;
        end
      end
    end
  end

  // Allocation FSM: latch, scan for a free run, commit, report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DSRAM_STATE_IDLE;
      own_q      <= 1'b0;
      n_q        <= '0;
      run        <= '0;
      cursor     <= '0;
      base       <= '0;
      cidx       <= '0;
      fail_q     <= 1'b0;
      alloc_done <= 1'b0;
      alloc_fail <= 1'b0;
      alloc_base <= '0;
      free_done  <= 1'b0;
    end else begin
      alloc_done <= 1'b0;
      alloc_fail <= 1'b0;
      free_done  <= 1'b0;
      unique case (state)
        DSRAM_STATE_IDLE: begin
          free_done <= free_req;
          if (alloc_req) begin
            own_q  <= alloc_owner;
            n_q    <= alloc_n_banks;
            cursor <= '0;
            run    <= '0;
            fail_q <= (alloc_n_banks == '0);
            state  <= (alloc_n_banks == '0) ? DSRAM_STATE_DONE
                                            : DSRAM_STATE_SCAN;
          end
        end
        DSRAM_STATE_SCAN: begin
          cursor <= cursor + ONE_B;
          if (scan_free && (run + ONE_N == n_q)) begin
            base  <= scan_base;
            cidx  <= scan_base;
            run   <= n_q;
            state <= DSRAM_STATE_COMMIT;
          end else begin
            run <= scan_free ? run + ONE_N : '0;
            if (cursor == LAST) begin
              fail_q <= 1'b1;
              state  <= DSRAM_STATE_DONE;
            end
          end
        end
        DSRAM_STATE_COMMIT: begin
          cidx <= cidx + ONE_B;
          run  <= run - ONE_N;
          if (run == ONE_N) begin
            state <= DSRAM_STATE_DONE;
          end
        end
        DSRAM_STATE_DONE: begin
          alloc_done <= 1'b1;
          alloc_fail <= fail_q;
          alloc_base <= fail_q ? '0 : base;
          state      <= DSRAM_STATE_IDLE;
        end
        default: state <= DSRAM_STATE_IDLE;
      endcase
    end
  end

endmodule
